// File: rtl/data_mem_hs.sv
// Load/store data memory with valid/ready request and response channels, programmable latency.
// Optional DMEM_BOUNDS_CHECK_EN: faults any access whose address bits above the word index are non-zero.
module data_mem_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OB    = $clog2(BYTES);
  localparam int IW    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              wait_cnt;
  logic                    lat_we;
  logic [2:0]              lat_funct3;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [DATA_WIDTH-1:0]   ram [MEM_DEPTH];

  logic                    src_we;
  logic [2:0]              src_funct3;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [DATA_WIDTH-1:0]   src_wdata;
  logic [OB-1:0]           offset;
  logic [IW-1:0]           idx;
  logic [OB-1:0]           align_mask;
  logic                    legal;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    acc_err;
  logic                    do_access;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [DATA_WIDTH-1:0]   wshift;
  logic [DATA_WIDTH-1:0]   load_data;
  logic [BYTES-1:0]        lane_en;

  // With zero wait states the access happens on the acceptance edge, so it must use the live request.
  assign src_we     = (state == S_IDLE) ? req_we     : lat_we;
  assign src_funct3 = (state == S_IDLE) ? req_funct3 : lat_funct3;
  assign src_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
  assign src_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;

  assign offset = src_addr[OB-1:0];
  assign idx    = src_addr[OB +: IW];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = |src_addr[ADDR_WIDTH-1:OB+IW];
`else
  assign out_of_range = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (req_valid) next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == 4'd0) next_state = S_RESP;
      S_RESP:  if (rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state == S_IDLE);
    rsp_valid = (state == S_RESP);
  end

  assign do_access = rst_n && (next_state == S_RESP) && (state != S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= 4'd0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else if (state == S_IDLE && req_valid) begin
      wait_cnt   <= 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr;
      lat_wdata  <= req_wdata;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    legal = 1'b0;
    case (src_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b011:                 legal = (DATA_WIDTH == 64);
      3'b100, 3'b101:         legal = !src_we;
      3'b110:                 legal = !src_we && (DATA_WIDTH == 64);
      default:                legal = 1'b0;
    endcase
    case (src_funct3[1:0])
      2'd0:    align_mask = '0;
      2'd1:    align_mask = OB'(1);
      2'd2:    align_mask = OB'(3);
      default: align_mask = OB'(7);
    endcase
    misaligned = |(offset & align_mask);
    acc_err    = !legal || misaligned || out_of_range;
  end

  always_comb begin
    shifted   = ram[idx] >> {offset, 3'b000};
    load_data = '0;
    if (!acc_err && !src_we) begin
      case (src_funct3)
        3'b000:  load_data = DATA_WIDTH'($signed(shifted[7:0]));
        3'b001:  load_data = DATA_WIDTH'($signed(shifted[15:0]));
        3'b010:  load_data = DATA_WIDTH'($signed(shifted[31:0]));
        3'b100:  load_data = DATA_WIDTH'(shifted[7:0]);
        3'b101:  load_data = DATA_WIDTH'(shifted[15:0]);
        3'b110:  load_data = DATA_WIDTH'(shifted[31:0]);
        default: load_data = shifted;
      endcase
    end
  end

  always_comb begin
    wshift  = src_wdata << {offset, 3'b000};
    lane_en = '0;
    for (int b = 0; b < BYTES; b++) begin
      lane_en[b] = (b >= int'(offset)) && (b < int'(offset) + (1 << src_funct3[1:0]));
    end
  end

  // RAM has no reset; do_access is already gated by rst_n so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (do_access && src_we && !acc_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (lane_en[b]) ram[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= load_data;
      rsp_err   <= acc_err;
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: a 32-bit zero-wait instance and a 64-bit three-wait instance
// checked against a byte-array reference model under random and directed traffic.
module tb_data_mem_hs;

  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_we     [2];
  logic        rsp_ready  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic        rsp_err    [2];
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  bit [7:0]    mem_model [2][512];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  data_mem_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) dut32 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0][31:0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rdata32), .rsp_err(rsp_err[0])
  );

  data_mem_hs #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(WS1)) dut64 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rdata64), .rsp_err(rsp_err[1])
  );

  function automatic logic [63:0] rdata_of(input int sel);
    return (sel != 0) ? rdata64 : {32'd0, rdata32};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte array, faults from the funct3/alignment/bounds rules.
  function automatic void model(input int sel, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [63:0] wd, output bit [63:0] rd, output bit err);
    int dw, nb, size, base;
    bit legal;
    bit [63:0] v;
    dw   = (sel != 0) ? 64 : 32;
    nb   = dw / 8 * 64;
    size = 1 << f3[1:0];
    if (we) legal = (f3 <= 3'd2) || (f3 == 3'd3 && dw == 64);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) || (dw == 64 && (f3 == 3 || f3 == 6));
    err = !legal || ((addr % size) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (addr >= nb) err = 1'b1;
`endif
    base = int'(addr % nb);
    rd   = 64'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mem_model[sel][base+i] = wd[8*i +: 8];
    end else begin
      v = 64'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_model[sel][base+i];
      if (!f3[2] && size < 8 && v[8*size-1]) begin
        for (int b = 8*size; b < 64; b++) v[b] = 1'b1;
      end
      if (dw == 32) v[63:32] = 32'd0;
      rd = v;
    end
  endfunction

  task automatic applyStimulus(input int sel, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                               input bit [63:0] wd, input int stall);
    bit [63:0] exp_rd;
    bit        exp_err;
    int        lat;
    int        ws;
    string     pfx;
    ws  = (sel != 0) ? WS1 : 0;
    pfx = (sel != 0) ? "d64" : "d32";
    model(sel, we, f3, addr, wd, exp_rd, exp_err);
    @(negedge clk);
    checkOutput({pfx, " idle ready"}, 64'(req_ready[sel]), 64'd1);
    req_valid[sel]  = 1'b1;
    req_we[sel]     = we;
    req_funct3[sel] = f3;
    req_addr[sel]   = addr;
    req_wdata[sel]  = wd;
    @(posedge clk);
    #1 req_valid[sel] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid[sel]) begin
        lat = c;
        break;
      end
      checkOutput({pfx, " busy ready"}, 64'(req_ready[sel]), 64'd0);
    end
    checkOutput({pfx, " latency"}, 64'(lat), 64'(1 + ws));
    checkOutput({pfx, " rdata"}, rdata_of(sel), exp_rd);
    checkOutput({pfx, " err"}, 64'(rsp_err[sel]), 64'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput({pfx, " stall valid"}, 64'(rsp_valid[sel]), 64'd1);
      checkOutput({pfx, " stall rdata"}, rdata_of(sel), exp_rd);
      checkOutput({pfx, " stall ready"}, 64'(req_ready[sel]), 64'd0);
    end
    rsp_ready[sel] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[sel] = 1'b0;
    checkOutput({pfx, " done valid"}, 64'(rsp_valid[sel]), 64'd0);
  endtask

  task automatic randomTraffic(input int sel, input int count);
    int nb, size;
    bit [2:0] f3;
    bit [31:0] addr;
    nb = (sel != 0) ? 512 : 256;
    for (int n = 0; n < count; n++) begin
      f3   = 3'($urandom_range(0, 7));
      size = 1 << f3[1:0];
      addr = 32'($urandom_range(0, nb - 1));
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size - 1);
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & ~32'(nb - 1));
      applyStimulus(sel, 1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom},
                    ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0; rsp_ready[s] = 1'b0;
      req_funct3[s] = 3'd0; req_addr[s] = 32'd0; req_wdata[s] = 64'd0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset ready", 64'(req_ready[s]), 64'd0);
      checkOutput("reset valid", 64'(rsp_valid[s]), 64'd0);
      checkOutput("reset rdata", rdata_of(s), 64'd0);
      checkOutput("reset err", 64'(rsp_err[s]), 64'd0);
      rst_n[s] = 1'b1;
    end
    #1;
    checkOutput("post reset ready d32", 64'(req_ready[0]), 64'd1);
    checkOutput("post reset ready d64", 64'(req_ready[1]), 64'd1);

    // Fill both memories so the model never has to reason about unwritten RAM.
    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b1, 3'b010, 32'(i * 4), {32'd0, $urandom}, 0);
    for (int i = 0; i < 64; i++) applyStimulus(1, 1'b1, 3'b011, 32'(i * 8), {$urandom, $urandom}, 0);

    applyStimulus(0, 1'b1, 3'b010, 32'h10, 64'hDEADBEEF, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b010, 32'h10, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b000, 32'h13, 64'h80, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'd0, 0);
    applyStimulus(0, 1'b0, 3'b000, 32'h13, 64'd0, 0);
    applyStimulus(0, 1'b0, 3'b100, 32'h13, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b001, 32'h12, 64'h1234, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'd0, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h11, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b001, 32'h13, 64'hFFFF, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h10, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b011, 32'h18, 64'h1, 0);
    applyStimulus(0, 1'b0, 3'b011, 32'h18, 64'd0, 0);
    applyStimulus(0, 1'b1, 3'b010, 32'h200, 64'hA5A55A5A, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h0, 64'd0, 0);
    applyStimulus(0, 1'b0, 3'b010, 32'h200, 64'd0, 0);

    applyStimulus(1, 1'b1, 3'b011, 32'h8, 64'h0123456789ABCDEF, 0);
    applyStimulus(1, 1'b0, 3'b110, 32'hC, 64'd0, 0);
    applyStimulus(1, 1'b0, 3'b010, 32'h8, 64'd0, 5);
    applyStimulus(1, 1'b0, 3'b011, 32'h8, 64'd0, 0);
    applyStimulus(1, 1'b0, 3'b011, 32'h204, 64'd0, 0);

    // Reset during WAIT must drop the response and discard the pending store.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1] = 32'h20; req_wdata[1] = 64'h55;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    checkOutput("abort valid", 64'(rsp_valid[1]), 64'd0);
    checkOutput("abort ready", 64'(req_ready[1]), 64'd0);
    repeat (4) @(negedge clk);
    rst_n[1] = 1'b1;
    #1 checkOutput("abort recover ready", 64'(req_ready[1]), 64'd1);
    applyStimulus(1, 1'b0, 3'b010, 32'h20, 64'd0, 0);
    applyStimulus(1, 1'b0, 3'b011, 32'h20, 64'd0, 0);

    randomTraffic(0, 300);
    randomTraffic(1, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
Name: data_mem_hs

Overview:
- Parametrised next-generation RISC-V load/store data memory for the LSU side of the core.
- Single-port RAM behind a valid/ready request channel and a valid/ready response channel.
- Programmable access latency; per-byte write lanes; sign/zero-extending loads; misalignment fault reporting.
- Supports RV32 (word) and RV64 (doubleword) data paths.

Parameters:
- DATA_WIDTH, 32: data path width; legal values 32 or 64.
- ADDR_WIDTH, 32: byte address width.
- MEM_DEPTH, 64: number of DATA_WIDTH-wide words; power of two.
- WAIT_STATES, 0: extra cycles between request acceptance and response; 0..15.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- rsp_err  out  1  access faulted.

Behaviour:
- Offset bits OB = log2(DATA_WIDTH/8); word index = req_addr[OB +: log2(MEM_DEPTH)]. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Reset, asynchronous on rst_n low: state=IDLE, req_ready=0 while asserted and 1 after, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not reset.
- FSM IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata, then go to WAIT if WAIT_STATES>0, else go to RESP.
- FSM WAIT:
  - req_ready=0.
  - Counter loads WAIT_STATES-1 on acceptance and decrements each cycle.
  - On 0, perform the access and go to RESP.
- FSM RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE. req_ready stays 0, so there is no back-to-back acceptance in the same cycle.
- Total request-to-response latency is 1+WAIT_STATES cycles.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. With DATA_WIDTH=64 also 011 LD and 110 LWU.
  - Stores: 000, 001, 010; plus 011 when DATA_WIDTH=64.
  - Any other value sets rsp_err=1.
- Alignment: address offset must be a multiple of the access size. Misaligned → rsp_err=1, rsp_rdata=0, no RAM write.
- Stores write only the addressed byte lanes, taking data from the low bytes of wdata; other lanes are unchanged.
- Loads select the lanes at the offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) to DATA_WIDTH.
- The access is performed exactly once, on the cycle the FSM enters RESP. Stores occur even if rsp_ready is stalled.
- rst_n asserted mid-transaction aborts it. A store that has not yet reached RESP is not written.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined: upper address bits above the index range must be zero. Otherwise rsp_err=1, no write, rdata=0.
- Undefined: upper bits are ignored and the address wraps.

Test Plan:
- Reset / basic store-load (DATA_WIDTH=32, WAIT_STATES=0):
  - rst_n low, then high → req_ready=1, rsp_valid=0.
  - SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF 1 cycle after acceptance, rsp_err=0.
- Byte lanes:
  - SB 0x80 @0x13 over 0x00000000 → LW @0x10 gives 0x80000000.
  - LB @0x13 gives 0xFFFFFF80; LBU @0x13 gives 0x00000080.
  - SH 0x1234 @0x12 → LW gives 0x12340000.
- Misalignment: LW @0x11 or SH @0x13 → rsp_err=1, rsp_rdata=0; a following LW @0x10 shows memory unchanged.
- Wait states / backpressure (WAIT_STATES=3):
  - rsp_valid rises 4 cycles after acceptance.
  - Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0 throughout.
- Reset mid-op: accept SW 0x55 @0x20, assert rst_n during WAIT → rsp_valid=0 at once; a later LW @0x20 returns the prior value.
- Width/wrap:
  - DATA_WIDTH=64: SD 0x0123456789ABCDEF @0x8 then LWU @0xC → 0x0000000001234567.
  - Without DMEM_BOUNDS_CHECK_EN, an access at 0x200 aliases 0x0 (MEM_DEPTH=64).
  - With the macro, the 0x200 access gives rsp_err=1.
